// File: rtl/serial_frame_transmitter_pkg.sv
// Shared definitions for the framed serial transmitter: parity mode codes and FSM states.
package serial_frame_transmitter_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

endpackage

// File: rtl/serial_frame_transmitter_baud_tick_gen.sv
// Bit-period divider: emits a one-cycle tick every CLKS_PER_BIT enabled cycles while run is high.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
    end
  end

  assign tick = run && en && (count == LAST_COUNT);

endmodule

// File: rtl/serial_frame_transmitter.sv
// Framed serial transmitter: start bit, WIDTH data bits, optional parity, STOP_BITS stop bits.
module serial_frame_transmitter
  import serial_frame_transmitter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out,
  output logic             rdy,
  output logic             co
);

  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  txState_e         state;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shiftNext;
  logic [BCNT_W-1:0] bitCnt;
  logic             stopCnt;
  logic             parityBit;
  logic             serReg;
  logic             rdyReg;
  logic             coReg;
  logic             tick;

  function automatic logic headBit(input logic [WIDTH-1:0] word);
    return (LSB_FIRST != 0) ? word[0] : word[WIDTH-1];
  endfunction

  always_comb begin
    shiftNext = (LSB_FIRST != 0) ? (shiftReg >> 1) : (shiftReg << 1);
  end

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .run (state != IDLE),
    .tick(tick)
  );

  // NOTE: the shift register is a handful of flops, so it is reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      stopCnt   <= 1'b0;
      parityBit <= 1'b0;
      serReg    <= 1'b1;
      rdyReg    <= 1'b1;
      coReg     <= 1'b0;
    end else if (en) begin
      coReg <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            shiftReg  <= par_in;
            parityBit <= (PARITY_MODE == PARITY_ODD) ? ~(^par_in) : ^par_in;
            rdyReg    <= 1'b0;
            serReg    <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            bitCnt <= '0;
            serReg <= headBit(shiftReg);
            state  <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shiftReg <= shiftNext;
            if (bitCnt == LAST_BIT) begin
              stopCnt <= 1'b0;
              if (PARITY_MODE != PARITY_NONE) begin
                serReg <= parityBit;
                state  <= PARITY;
              end else begin
                serReg <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
              serReg <= headBit(shiftNext);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            serReg <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stopCnt == LAST_STOP) begin
              coReg  <= 1'b1;
              rdyReg <= 1'b1;
              state  <= IDLE;
            end else begin
              stopCnt <= stopCnt + 1'b1;
            end
          end
        end
        default: begin
          serReg <= 1'b1;
          rdyReg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign ser_out = serReg;
  assign rdy     = rdyReg;
  assign co      = coReg;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor decodes ser_out and checks timing.
module tb_serial_frame_transmitter;

  typedef struct {
    string bits;     // transmitted order, first bit leftmost
    int    cpb;
    int    latency;  // clk edges from accept to co
    int    gap;      // edges from previous co to accept, -1 = don't care
    bit    abort;
  } frame_t;

  logic clk = 1'b0;
  logic rst;

  logic       enA, ldA, serA, rdyA, coA;
  logic [7:0] parA;
  logic       enB, ldB, serB, rdyB, coB;
  logic [7:0] parB;
  logic       enC, ldC, serC, rdyC, coC;
  logic [7:0] parC;

  int   sel;
  logic serMon, rdyMon, coMon, enMon;

  frame_t expQ[$];
  int checks   = 0;
  int failures = 0;
  bit busy     = 1'b0;

  always #5 clk = ~clk;

  serial_frame_transmitter #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .LSB_FIRST(1)
  ) dutA (
    .clk(clk), .rst(rst), .en(enA), .ld(ldA), .par_in(parA),
    .ser_out(serA), .rdy(rdyA), .co(coA)
  );

  serial_frame_transmitter #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .LSB_FIRST(0)
  ) dutB (
    .clk(clk), .rst(rst), .en(enB), .ld(ldB), .par_in(parB),
    .ser_out(serB), .rdy(rdyB), .co(coB)
  );

  serial_frame_transmitter #(
    .WIDTH(8), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(2), .LSB_FIRST(1)
  ) dutC (
    .clk(clk), .rst(rst), .en(enC), .ld(ldC), .par_in(parC),
    .ser_out(serC), .rdy(rdyC), .co(coC)
  );

  always_comb begin
    serMon = serA; rdyMon = rdyA; coMon = coA; enMon = enA;
    if (sel == 1) begin
      serMon = serB; rdyMon = rdyB; coMon = coB; enMon = enB;
    end else if (sel == 2) begin
      serMon = serC; rdyMon = rdyC; coMon = coC; enMon = enC;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkStr(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic void pushFrame(input string bits, input int cpb, input int lat,
                                    input int gap, input bit abort);
    frame_t f;
    f.bits = bits; f.cpb = cpb; f.latency = lat; f.gap = gap; f.abort = abort;
    expQ.push_back(f);
  endfunction

  task automatic waitIdle(input string name, input int maxCycles);
    int i;
    for (i = 0; i < maxCycles; i++) begin
      @(negedge clk); #1;
      if (expQ.size() == 0 && !busy) break;
    end
    check(name, (expQ.size() == 0 && !busy), 1);
  endtask

  // Monitor: a falling rdy marks an accept; collect en-qualified samples until co or reset.
  initial begin : monitorProc
    frame_t exp;
    string  samples, dec;
    bit     prevRdy, coPending, frozeOk, stableOk, aborted, done;
    logic   enEdge, last;
    int     sinceCo, lat;
    prevRdy   = 1'b1;
    coPending = 1'b0;
    sinceCo   = 1000;
    forever begin
      @(negedge clk);
      if (sinceCo < 1000) sinceCo++;
      if (coPending) begin
        check("co single cycle", coMon, 0);
        coPending = 1'b0;
        busy      = 1'b0;
      end
      if (rst === 1'b1 && prevRdy && rdyMon === 1'b0) begin
        busy = 1'b1;
        if (expQ.size() == 0) begin
          check("unexpected frame", 1, 0);
          exp.bits = ""; exp.cpb = 1; exp.latency = 0; exp.gap = -1; exp.abort = 1'b0;
        end else begin
          exp = expQ.pop_front();
        end
        if (exp.gap >= 0) check("accept gap after co", sinceCo, exp.gap);
        samples = (serMon === 1'b1) ? "1" : "0";
        last    = serMon;
        frozeOk = 1'b1;
        aborted = 1'b0;
        done    = 1'b0;
        lat     = 0;
        while (!done && lat < 400) begin
          @(posedge clk); enEdge = enMon;
          @(negedge clk); lat++;
          if (rst !== 1'b1) begin
            aborted = 1'b1; done = 1'b1;
          end else if (coMon === 1'b1) begin
            done = 1'b1;
          end else if (enEdge === 1'b1) begin
            samples = {samples, (serMon === 1'b1) ? "1" : "0"};
          end else if (serMon !== last) begin
            frozeOk = 1'b0;
          end
          last = serMon;
        end
        check("frame ended within bound", done, 1);
        check("frame aborted", aborted, exp.abort);
        if (aborted) begin
          check("reset ser_out", serMon, 1);
          check("reset rdy", rdyMon, 1);
          check("reset co", coMon, 0);
          busy = 1'b0;
        end else if (done) begin
          check("co latency", lat, exp.latency);
          check("rdy with co", rdyMon, 1);
          check("ser_out frozen while en low", frozeOk, 1);
          check("enabled sample count", samples.len(), exp.bits.len() * exp.cpb);
          dec      = "";
          stableOk = 1'b1;
          for (int k = 0; k < samples.len(); k++) begin
            if (k % exp.cpb == 0) dec = {dec, samples.substr(k, k)};
            else if (samples[k] != samples[k-1]) stableOk = 1'b0;
          end
          checkStr("serial bits", dec, exp.bits);
          check("bit held full period", stableOk, 1);
          sinceCo   = 0;
          coPending = 1'b1;
        end else begin
          busy = 1'b0;
        end
      end
      prevRdy = (rdyMon === 1'b1);
    end
  end

  initial begin : stimulus
    int i;
    rst = 1'b0;
    enA = 1'b1; ldA = 1'b0; parA = '0;
    enB = 1'b1; ldB = 1'b0; parB = '0;
    enC = 1'b1; ldC = 1'b0; parC = '0;
    sel = 0;
    repeat (2) @(negedge clk);
    check("reset serA", serA, 1); check("reset rdyA", rdyA, 1); check("reset coA", coA, 0);
    check("reset serB", serB, 1); check("reset rdyB", rdyB, 1); check("reset coB", coB, 0);
    check("reset serC", serC, 1); check("reset rdyC", rdyC, 1); check("reset coC", coC, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ld with en low must be ignored.
    enA = 1'b0; ldA = 1'b1; parA = 8'hFF;
    repeat (3) @(negedge clk);
    check("ld ignored when en low rdy", rdyA, 1);
    check("ld ignored when en low ser", serA, 1);
    ldA = 1'b0; enA = 1'b1;
    @(negedge clk);

    // Even parity, LSB first; par_in changes mid-frame must not matter.
    pushFrame("01000101101", 4, 44, -1, 1'b0);
    ldA = 1'b1; parA = 8'b11010001;
    @(negedge clk);
    ldA = 1'b0; parA = 8'h5A;
    waitIdle("frame1 drained", 200);

    // ld held high through a frame: second word waits for the cycle after co.
    pushFrame("01000101101", 4, 44, -1, 1'b0);
    pushFrame("01101000011", 4, 44, 1, 1'b0);
    ldA = 1'b1; parA = 8'b11010001;
    @(negedge clk);
    parA = 8'b00001011;
    for (i = 0; i < 200 && coA !== 1'b1; i++) @(negedge clk);
    check("held-ld first co seen", coA, 1);
    @(negedge clk);
    ldA = 1'b0;
    waitIdle("back-to-back drained", 200);

    // en dropped for 10 cycles during DATA delays co by 10.
    pushFrame("01000101101", 4, 54, -1, 1'b0);
    ldA = 1'b1; parA = 8'b11010001;
    @(negedge clk);
    ldA = 1'b0;
    repeat (9) @(negedge clk);
    enA = 1'b0;
    repeat (10) @(negedge clk);
    enA = 1'b1;
    waitIdle("en freeze drained", 200);

    // Asynchronous reset mid-frame aborts it; next frame is clean.
    pushFrame("", 4, 0, -1, 1'b1);
    ldA = 1'b1; parA = 8'b11010001;
    @(negedge clk);
    ldA = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    pushFrame("01101000011", 4, 44, -1, 1'b0);
    @(negedge clk);
    ldA = 1'b1; parA = 8'b00001011;
    @(negedge clk);
    ldA = 1'b0;
    waitIdle("post-reset frame drained", 200);

    // Odd parity, MSB first.
    sel = 1;
    @(negedge clk);
    pushFrame("01101000111", 4, 44, -1, 1'b0);
    ldB = 1'b1; parB = 8'b11010001;
    @(negedge clk);
    ldB = 1'b0;
    waitIdle("odd parity drained", 200);

    // One clock per bit, no parity, two stop bits.
    sel = 2;
    @(negedge clk);
    pushFrame("01010010111", 1, 11, -1, 1'b0);
    ldC = 1'b1; parC = 8'hA5;
    @(negedge clk);
    ldC = 1'b0;
    waitIdle("fast frame drained", 100);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_transmitter.md
Name: serial_frame_transmitter

Overview:
Parametrised serial transmitter. It loads a WIDTH-bit parallel word and shifts it out as a framed serial stream: a start bit, the data bits, an optional parity bit, then one or two stop bits. An internal bit-period divider sets the bit time, and a ready/load handshake gates new words. It drives the serial line of the datapath and raises co once per completed frame.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, en-qualified clk cycles per serial bit (>=1)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bit periods (1 or 2)
LSB_FIRST, 1, 1 = data sent bit 0 first, 0 = bit WIDTH-1 first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
en  input  1  clock enable; 0 freezes the divider, state and shift register
ld  input  1  load request; sampled only when rdy=1 and en=1
par_in  input  WIDTH  parallel data word
ser_out  output  1  serial line; idle level is 1
rdy  output  1  1 = idle and able to accept ld
co  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset (rst=0, any time, asynchronous): ser_out=1, rdy=1, co=0, state IDLE, divider=0, shift register=0. A frame in progress is aborted with no co.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_MODE!=0) -> STOP -> IDLE.
- Accept: on a clk edge with rdy=1, en=1, ld=1:
  - latch par_in into the shift register;
  - compute the parity bit: even mode = XOR of the data bits; odd mode = its inverse;
  - set rdy<=0, ser_out<=0, state<=START, divider<=0.
  - ser_out is low starting the cycle after the accept edge.
- Divider: counts 0..CLKS_PER_BIT-1 on en=1 cycles while not IDLE. A bit tick occurs when the count equals CLKS_PER_BIT-1; the count then wraps to 0. Each state is held for exactly CLKS_PER_BIT en-cycles per bit.
- DATA: ser_out carries the current data bit. On each tick the register shifts right (LSB_FIRST=1) or left (LSB_FIRST=0). After WIDTH ticks, move to PARITY or STOP.
- PARITY: ser_out = parity bit for one bit period.
- STOP: ser_out=1 for STOP_BITS bit periods.
- Final stop-bit tick: co<=1 for exactly one cycle; rdy<=1; state<=IDLE; ser_out stays 1.
- Frame timing: frame length = CLKS_PER_BIT*(1+WIDTH+P+STOP_BITS) en-cycles, where P = (PARITY_MODE!=0).
- Back-to-back frames: ld is accepted no earlier than the cycle after co, so there is a minimum of 1 idle cycle between frames.
- en=0: all registers hold (ser_out, rdy, co hold; co is cleared on the next en=1 edge). ld is ignored.
- ld while rdy=0: ignored. par_in changes mid-frame have no effect.
- CLKS_PER_BIT=1: one tick every en cycle; the divider width collapses to 1 bit.
- Widths: divider $clog2(CLKS_PER_BIT) (min 1); bit counter $clog2(WIDTH+1).

Decomposition:
- Shared package: PARITY_NONE/EVEN/ODD codes; state encoding constants (IDLE, START, DATA, PARITY, STOP).
- Sub-module baud_tick_gen: parameter CLKS_PER_BIT; inputs clk, rst, en, run; output tick. The counter clears when run=0.
- The FSM and shift register stay in the top module.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=4, PARITY_MODE=1, LSB_FIRST=1, par_in=8'b11010001, one ld pulse -> ser_out sequence 0,1,0,0,0,1,0,1,1,0(parity),1, each bit held 4 cycles. co pulses 44 cycles after accept; rdy returns 1 on the same edge.
2. Same word with PARITY_MODE=2 and LSB_FIRST=0 -> data 1,1,0,1,0,0,0,1, parity bit 1. Frame still 44 cycles.
3. ld held high with par_in=8'b00001011 during the scenario 1 frame -> word ignored. The next frame starts only on the cycle after co and carries 00001011.
4. Drop en for 10 cycles during DATA -> ser_out and divider frozen. co is delayed by exactly 10 cycles (54 after accept).
5. rst=0 asynchronously at cycle 20 of a frame -> ser_out=1, rdy=1 immediately. No co; next ld starts a clean frame.
6. CLKS_PER_BIT=1, PARITY_MODE=0, STOP_BITS=2, WIDTH=8 -> frame 11 cycles, last two bits 1. co 11 cycles after accept.
